ex_operand_stage: RTL
=====================

# ex_operand_stage

ID/EX pipeline register and operand-selection stage that feeds the ALU in the 32-bit RISC-V core. It captures a decoded instruction from decode under a valid/ready handshake. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and stalls on load-use. It presents `SrcA`, `SrcB` and the 4-bit ALU `Operation` to the execute stage together with the control bits that travel with them.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `REG_ADDR_W`, 5, register index width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid` / `id_ready`  in / out  1 / 1  decode handshake
- `id_rs1_data`, `id_rs2_data`, `id_imm`, `id_pc`  in  DATA_WIDTH each  raw operands
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_ADDR_W each  register indices
- `id_alu_op`  in  OPCODE_LENGTH  ALU operation
- `id_src_a_pc`, `id_src_b_imm`, `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1 each  operand selects and control bits
- `flush`  in  1  kill the held instruction (taken branch/jump)
- `exm_rd`, `exm_reg_write`, `exm_mem_read`, `exm_result`  in  5/1/1/32  EX/MEM forwarding source
- `wb_rd`, `wb_reg_write`, `wb_result`  in  5/1/32  MEM/WB forwarding source
- `ex_valid` / `ex_ready`  out / in  1 / 1  execute handshake
- `SrcA`, `SrcB`  out  DATA_WIDTH  ALU operands
- `Operation`  out  OPCODE_LENGTH  ALU operation
- `ex_store_data`  out  DATA_WIDTH  forwarded rs2 for stores
- `ex_rd`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_pc`  out  passthrough

## Operation
- One holding register set plus a `held_valid` bit. Outputs are driven from it; forwarding is combinational on the output side, using current `exm_*` and `wb_*` inputs.
- Forward rule per operand, with rs = `id_rs1` or `id_rs2` as captured:
  - rs = 0: never forwarded.
  - Else if `exm_reg_write` and `exm_rd` = rs: use `exm_result`.
  - Else if `wb_reg_write` and `wb_rd` = rs: use `wb_result`.
  - Else: use the captured register value.
- `SrcA` = captured PC if `src_a_pc`, else forwarded rs1. `SrcB` = captured imm if `src_b_imm`, else forwarded rs2. `ex_store_data` is always forwarded rs2.
- Load-use hazard: `held_valid` & `exm_mem_read` & `exm_rd`≠0 & `exm_rd` matches a used source (rs1 if !src_a_pc; rs2 if !src_b_imm or mem_write).
- While the hazard holds: `ex_valid`=0 (bubble), the instruction is held, and `id_ready`=0.
- `ex_valid` = `held_valid` & !hazard.
- `id_ready` = (!`held_valid` | (`ex_valid` & `ex_ready`)) & !hazard.
- Capture: on a cycle with `id_valid` & `id_ready` & !`flush`, load all fields and set `held_valid`=1. If the held instruction retires (`ex_valid` & `ex_ready`) with no capture, clear `held_valid`.
- `flush` has priority over retire and capture. Next edge: `held_valid`=0; an incoming ID transfer that same cycle is dropped.
- `Operation` passes through unmodified; encodings are not checked.

## Timing
- Latency one cycle: an instruction accepted at edge N is presented on `ex_*` after edge N and can retire at edge N+1.
- Full throughput of one instruction per cycle when `ex_ready`=1 and there are no hazards.
- `ex_ready`=0 with `ex_valid`=1: all outputs stable except `SrcA`/`SrcB`/`ex_store_data`, which may change if forwarding sources change.
- Reset asserted asynchronously: `held_valid`=0 and all holding registers 0. Hence `ex_valid`=0, `SrcA`=`SrcB`=0, `Operation`=4'b0000, all control outputs 0.
- Reset mid-operation discards the held instruction. `id_ready`=1 is driven from the first cycle after deassertion.

## Configuration
- `EX_OPSTAGE_PERF_EN` defined: adds outputs `perf_bubble_cnt` and `perf_flush_cnt`, each 32 bits.
  - `perf_bubble_cnt` increments each cycle the load-use hazard holds.
  - `perf_flush_cnt` increments each cycle `flush` kills a valid held instruction.
  - Both saturate at 2^32-1 and are reset to 0.
- Undefined: neither the ports nor the counters exist.

## Structure
- Shared package `core_pkg`: ALU op constants `ALU_AND`=4'b0000, `ALU_OR`=0001, `ALU_XOR`=0011, `ALU_SLL`=0100, `ALU_SRL`=0101, `ALU_LT`=0110, `ALU_GE`=0111, `ALU_EQ`=1000, `ALU_NE`=1001, `ALU_SUB`=1010, `ALU_ADD`=1011, `ALU_SLT`=1100. Also the `fwd_sel_e` enum {FWD_REG, FWD_EXM, FWD_WB}.
- Sub-module `operand_fwd_mux`: forward-select plus data mux for one source register, instantiated twice (rs1, rs2).

## Test plan
- Capture `ALU_ADD`, rs1_data=5, imm=7, `src_b_imm`=1, no hazard -> next cycle `ex_valid`=1, `SrcA`=5, `SrcB`=7, `Operation`=1011.
- Both sources match: `exm_rd`=`wb_rd`=3, `exm_result`=0xAA, `wb_result`=0xBB, rs1=3 -> `SrcA`=0xAA. Same with `exm_reg_write`=0 -> `SrcA`=0xBB. With rs1=0 -> `SrcA`=captured value.
- Load-use: `exm_mem_read`=1, `exm_rd`=4, held rs2=4 -> `ex_valid`=0 and `id_ready`=0 for 1 cycle; after `exm_*` clears, `ex_valid`=1 with `SrcB`=`wb_result`. With `EX_OPSTAGE_PERF_EN`, `perf_bubble_cnt`=1.
- `ex_ready`=0 for 3 cycles with `id_valid`=1 -> `id_ready`=0 throughout, outputs held; first cycle `ex_ready`=1 retires and accepts the next instruction the same edge.
- `flush`=1 in the same cycle as an ID transfer -> next cycle `ex_valid`=0 and the new instruction is lost.
- `rst_n` pulsed low while valid with `Operation`=1100 -> immediately `ex_valid`=0, `Operation`=0000, `SrcA`=0.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared ALU opcode constants and forwarding-select encoding.
// Revision    : 1.0
// ============================================================================
package core_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_LT  = 4'b0110;
    localparam logic [3:0] ALU_GE  = 4'b0111;
    localparam logic [3:0] ALU_EQ  = 4'b1000;
    localparam logic [3:0] ALU_NE  = 4'b1001;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_ADD = 4'b1011;
    localparam logic [3:0] ALU_SLT = 4'b1100;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/operand_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : operand_fwd_mux
// Description : Forward-source select and data mux for one source register.
// Revision    : 1.0
// ============================================================================
module operand_fwd_mux
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [DATA_WIDTH-1:0] reg_data_i,
    input  logic [REG_ADDR_W-1:0] exm_rd_i,
    input  logic                  exm_reg_write_i,
    input  logic [DATA_WIDTH-1:0] exm_result_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_reg_write_i,
    input  logic [DATA_WIDTH-1:0] wb_result_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    fwd_sel_e w_sel;

    // x0 is hardwired zero, so a write targeting it must never be forwarded.
    always_comb begin
        w_sel = FWD_REG;
        if (rs_i != '0) begin
            if (exm_reg_write_i && (exm_rd_i == rs_i)) begin
                w_sel = FWD_EXM;
            end else if (wb_reg_write_i && (wb_rd_i == rs_i)) begin
                w_sel = FWD_WB;
            end
        end
    end

    always_comb begin
        data_o = reg_data_i;
        case (w_sel)
            FWD_EXM: data_o = exm_result_i;
            FWD_WB:  data_o = wb_result_i;
            default: data_o = reg_data_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_operand_stage
// Description : ID/EX holding register with operand forwarding and load-use
//               stall. Optional perf counters under EX_OPSTAGE_PERF_EN.
// Revision    : 1.0
// ============================================================================
module ex_operand_stage
    import core_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_src_a_pc,
    input  logic                     id_src_b_imm,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     flush,
    input  logic [REG_ADDR_W-1:0]    exm_rd,
    input  logic                     exm_reg_write,
    input  logic                     exm_mem_read,
    input  logic [DATA_WIDTH-1:0]    exm_result,
    input  logic [REG_ADDR_W-1:0]    wb_rd,
    input  logic                     wb_reg_write,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic [DATA_WIDTH-1:0]    ex_pc
`ifdef EX_OPSTAGE_PERF_EN
    ,
    output logic [31:0]              perf_bubble_cnt,
    output logic [31:0]              perf_flush_cnt
`endif
);

    logic                     held_valid_q, held_valid_d;
    logic [DATA_WIDTH-1:0]    rs1_data_q, rs2_data_q, imm_q, pc_q;
    logic [REG_ADDR_W-1:0]    rs1_q, rs2_q, rd_q;
    logic [OPCODE_LENGTH-1:0] alu_op_q;
    logic                     src_a_pc_q, src_b_imm_q;
    logic                     reg_write_q, mem_read_q, mem_write_q;

    logic                  w_hazard, w_retire, w_capture;
    logic [DATA_WIDTH-1:0] w_fwd_rs1, w_fwd_rs2;

    operand_fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .rs_i            (rs1_q),
        .reg_data_i      (rs1_data_q),
        .exm_rd_i        (exm_rd),
        .exm_reg_write_i (exm_reg_write),
        .exm_result_i    (exm_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_result_i     (wb_result),
        .data_o          (w_fwd_rs1)
    );

    operand_fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .rs_i            (rs2_q),
        .reg_data_i      (rs2_data_q),
        .exm_rd_i        (exm_rd),
        .exm_reg_write_i (exm_reg_write),
        .exm_result_i    (exm_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_result_i     (wb_result),
        .data_o          (w_fwd_rs2)
    );

    // A load in EX/MEM has no data yet; stall only on sources actually consumed.
    assign w_hazard = held_valid_q && exm_mem_read && (exm_rd != '0) &&
                      ((!src_a_pc_q && (exm_rd == rs1_q)) ||
                       ((!src_b_imm_q || mem_write_q) && (exm_rd == rs2_q)));

    assign ex_valid  = held_valid_q && !w_hazard;
    assign w_retire  = ex_valid && ex_ready;
    assign id_ready  = (!held_valid_q || w_retire) && !w_hazard;
    assign w_capture = id_valid && id_ready && !flush;

    always_comb begin
        held_valid_d = held_valid_q;
        if (flush) begin
            held_valid_d = 1'b0;
        end else if (w_capture) begin
            held_valid_d = 1'b1;
        end else if (w_retire) begin
            held_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid_q <= 1'b0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            alu_op_q     <= '0;
            src_a_pc_q   <= 1'b0;
            src_b_imm_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            held_valid_q <= held_valid_d;
            if (w_capture) begin
                rs1_data_q  <= id_rs1_data;
                rs2_data_q  <= id_rs2_data;
                imm_q       <= id_imm;
                pc_q        <= id_pc;
                rs1_q       <= id_rs1;
                rs2_q       <= id_rs2;
                rd_q        <= id_rd;
                alu_op_q    <= id_alu_op;
                src_a_pc_q  <= id_src_a_pc;
                src_b_imm_q <= id_src_b_imm;
                reg_write_q <= id_reg_write;
                mem_read_q  <= id_mem_read;
                mem_write_q <= id_mem_write;
            end
        end
    end

    assign SrcA          = src_a_pc_q ? pc_q : w_fwd_rs1;
    assign SrcB          = src_b_imm_q ? imm_q : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign Operation     = alu_op_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_pc         = pc_q;

`ifdef EX_OPSTAGE_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (w_hazard && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (flush && held_valid_q && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;
`endif

endmodule
`default_nettype wire
